pt5_packer: RTL and testbench

PT5_PACKER -- requirements
Module: pt5_packer

---
 rtl/pt5_pkg.sv | 34 +++
 rtl/pt5_packer_if.sv | 25 ++
 rtl/pt5_packer.sv | 89 ++++++++
 tb/tb_pt5_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt5_pkg.sv
// Shared definitions for the base-3 trit packer/unpacker pair: trit codes,
// group size, byte range and the power-of-3 weight table.
package pt5_pkg;

  localparam logic [1:0] NEG     = 2'b00;
  localparam logic [1:0] ZERO    = 2'b01;
  localparam logic [1:0] POS     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam logic [1:0] PAD_CODE = ZERO;

  localparam int         PT5_TRITS    = 5;
  localparam logic [7:0] PT5_MAX_BYTE = 8'd242;

  localparam logic [7:0] PT5_WEIGHT [PT5_TRITS] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

  // The illegal code carries the arithmetic weight of a zero trit.
  function automatic logic [1:0] pt5_legal(input logic [1:0] code);
    return (code == ILLEGAL) ? ZERO : code;
  endfunction

  // Contribution of pad trits in positions first..PT5_TRITS-1.
  function automatic logic [7:0] pt5_pad(input logic [2:0] first);
    logic [7:0] sum;
    sum = '0;
    for (int j = 0; j < PT5_TRITS; j++) begin
      if (j >= int'(first)) begin
        sum = sum + 8'(PT5_WEIGHT[j] * {6'd0, PAD_CODE});
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/pt5_packer_if.sv
// Trit-in / byte-out stream bundle; master is the packer side, slave is the
// environment that supplies trits and consumes bytes.
interface pt5_packer_if;

  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_trit;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] m_count;
  logic       err;

  modport master (
    input  s_valid, s_trit, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count, err
  );

  modport slave (
    output s_valid, s_trit, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count, err
  );

endinterface

// File: rtl/pt5_packer.sv
// Packs up to five balanced trits into one byte (trit0 least significant).
// Define PT5_PACKER_CHECK_EN to get a sticky err flag on illegal trit codes.
module pt5_packer
  import pt5_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pt5_packer_if.master  bus
);

  logic [2:0] r_idx;
  logic [7:0] r_acc;
  logic [7:0] r_w;
  logic       r_m_valid;
  logic [7:0] r_m_data;
  logic [2:0] r_m_count;

  logic       w_s_ready;
  logic       w_accept;
  logic       w_close;
  logic [1:0] w_code;
  logic [2:0] w_idx_inc;
  logic [7:0] w_sum;
  logic [7:0] w_byte;

  assign w_s_ready = !r_m_valid || bus.m_ready;
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_code    = pt5_legal(bus.s_trit);
  assign w_idx_inc = r_idx + 3'd1;
  assign w_close   = w_accept && (bus.s_last || (r_idx == 3'(PT5_TRITS - 1)));
  assign w_sum     = r_acc + 8'(r_w * {6'd0, w_code});
  // Positions after the closing trit take the pad code; zero when the group is full.
  assign w_byte    = w_sum + pt5_pad(w_idx_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
      r_w   <= 8'd1;
    end else if (w_accept) begin
      if (w_close) begin
        r_idx <= '0;
        r_acc <= '0;
        r_w   <= 8'd1;
      end else begin
        r_idx <= w_idx_inc;
        r_acc <= w_sum;
        r_w   <= 8'(r_w * 8'd3);
      end
    end
  end

  // A closing trit may load a new byte in the same cycle the old one leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_count <= '0;
    end else if (w_close) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_byte;
      r_m_count <= w_idx_inc;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

`ifdef PT5_PACKER_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (bus.s_trit == ILLEGAL)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_count = r_m_count;

endmodule

// File: tb/tb_pt5_packer.sv
// Directed and random stimulus for pt5_packer, checked against a base-3
// reference model and a byte scoreboard; one line per delivered byte.
module tb_pt5_packer;
  import pt5_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pt5_packer_if bus();

  pt5_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] count;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  beat_t       exp_q[$];
  int          grp[$];
  int          rx_count = 0;
  logic [7:0]  last_data = '0;
  logic [2:0]  last_count = '0;
  bit          exp_err = 1'b0;
  bit          rand_ready = 1'b0;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int eff_code(input int c);
    return (c == 3) ? 1 : c;
  endfunction

  // Byte value of the current group: each position weighs 3**i, missing positions read as zero trits.
  function automatic beat_t close_group();
    beat_t b;
    int    v;
    v = 0;
    for (int i = 0; i < 5; i++) begin
      v += ((i < grp.size()) ? eff_code(grp[i]) : 1) * (3 ** i);
    end
    b.data  = 8'(v);
    b.count = 3'(grp.size());
    return b;
  endfunction

  task automatic send(input int c, input bit l, output int waits);
    int n;
    bit ok;
    bit closed;
    n = 0;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_trit  = 2'(c);
    bus.s_last  = l;
    forever begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      if (rand_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
      if (ok) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(n), 0);
        break;
      end
    end
    waits = n;
    if (ok) begin
      grp.push_back(c);
`ifdef PT5_PACKER_CHECK_EN
      if (c == 3) exp_err = 1'b1;
`endif
      closed = l || (grp.size() == 5);
      if (closed) begin
        exp_q.push_back(close_group());
        grp.delete();
        chk("latency_valid", bus.m_valid, 1);
        chk("latency_data", bus.m_data, exp_q[$].data);
        chk("latency_count", bus.m_count, exp_q[$].count);
      end
    end
  endtask

  task automatic send_seq(input int c0, input int c1, input int c2, input int c3, input int c4,
                          input int n, input bit last_end);
    int codes[5];
    int w;
    codes = '{c0, c1, c2, c3, c4};
    for (int i = 0; i < n; i++) begin
      send(codes[i], last_end && (i == n - 1), w);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    rand_ready  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_count", bus.m_count, 0);
    chk("rst_err", bus.err, 0);
    exp_q.delete();
    grp.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_s_ready", bus.s_ready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, hold_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("byte_expected", 32'(exp_q.size()), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("byte_data", bus.m_data, e.data);
          chk("byte_count", bus.m_count, e.count);
        end
        rx_count++;
        last_data  = bus.m_data;
        last_count = bus.m_count;
        $display("byte %0d: data=%02h count=%0d", rx_count, bus.m_data, bus.m_count);
        hold_pend = 1'b0;
      end else if (bus.m_valid) begin
        hold_pend = 1'b1;
        hold_data = bus.m_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rx0;
    int c;
    bit l;
    int rt_codes[5];

    bus.s_valid = 1'b0;
    bus.s_trit  = 2'b00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    #2;
    do_reset();

    bus.m_ready = 1'b1;
    send_seq(0, 0, 0, 0, 0, 5, 1'b0);
    drain();
    chk("all_neg_data", last_data, 8'h00);
    chk("all_neg_count", last_count, 5);
    send_seq(2, 2, 2, 2, 2, 5, 1'b0);
    drain();
    chk("all_pos_data", last_data, 8'hF2);
    send_seq(1, 1, 1, 1, 1, 5, 1'b0);
    drain();
    chk("all_zero_data", last_data, 8'h79);

    send_seq(2, 0, 0, 0, 0, 5, 1'b0);
    drain();
    chk("lsb_pos_data", last_data, 8'h02);
    rt_codes = '{2, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++)
      chk($sformatf("rt02_t%0d", i), 32'((int'(last_data) / (3 ** i)) % 3), 32'(rt_codes[i]));
    send_seq(0, 0, 0, 0, 2, 5, 1'b0);
    drain();
    chk("msb_pos_data", last_data, 8'hA2);
    rt_codes = '{0, 0, 0, 0, 2};
    for (int i = 0; i < 5; i++)
      chk($sformatf("rtA2_t%0d", i), 32'((int'(last_data) / (3 ** i)) % 3), 32'(rt_codes[i]));

    send_seq(2, 2, 0, 0, 0, 2, 1'b1);
    drain();
    chk("early_close_data", last_data, 8'h7D);
    chk("early_close_count", last_count, 2);

    rx0 = rx_count;
    send_seq(1, 2, 0, 1, 2, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    drain();
    chk("last_on_fifth_bytes", 32'(rx_count - rx0), 1);
    chk("last_on_fifth_count", last_count, 5);

    // Stall with a byte pending, then stream without bubbles.
    bus.m_ready = 1'b0;
    send_seq(1, 2, 0, 1, 2, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_s_ready", bus.s_ready, 0);
      chk("stall_m_data", bus.m_data, 8'hC4);
    end
    @(posedge clk);
    #1;
    rx0 = rx_count;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send($urandom_range(0, 2), 1'b0, w);
      chk("stream_no_wait", 32'(w), 0);
    end
    for (int i = 0; i < 3; i++) begin
      send($urandom_range(0, 2), 1'b1, w);
      chk("single_no_wait", 32'(w), 0);
    end
    drain();
    chk("stream_bytes", 32'(rx_count - rx0), 7);
    chk("single_count", last_count, 1);

    bus.m_ready = 1'b0;
    send_seq(2, 2, 2, 2, 2, 5, 1'b0);
    chk("pending_before_reset", bus.m_valid, 1);
    do_reset();

    bus.m_ready = 1'b1;
    rx0 = rx_count;
    send_seq(2, 2, 2, 0, 0, 3, 1'b0);
    do_reset();
    send_seq(1, 1, 1, 1, 1, 5, 1'b0);
    drain();
    chk("after_reset_bytes", 32'(rx_count - rx0), 1);
    chk("after_reset_data", last_data, 8'h79);

    send_seq(1, 3, 1, 1, 1, 5, 1'b0);
    drain();
    chk("illegal_data", last_data, 8'h79);
`ifdef PT5_PACKER_CHECK_EN
    chk("illegal_err", bus.err, 1);
`else
    chk("illegal_err", bus.err, 0);
`endif
    send_seq(1, 1, 1, 1, 1, 5, 1'b0);
    drain();
    chk("err_sticky", bus.err, exp_err);
    do_reset();

    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      c = $urandom_range(0, 3);
      l = ($urandom_range(0, 7) == 0);
      send(c, l, w);
    end
    bus.s_valid = 1'b0;
    if (grp.size() != 0) begin
      send(1, 1'b1, w);
      bus.s_valid = 1'b0;
    end
    drain();
    chk("random_err", bus.err, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
